// File: rtl/agc_ctr_pkg.sv
// Shared definitions for the involuntary counter-cycle scheduler:
// FSM state encoding, counter address width and default counter base address.
package agc_ctr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CYC  = 2'd1,
        ST_POST = 2'd2
    } ctr_state_e;

    localparam int CADR_W  = 6;
    localparam int STEAL_W = 4;

    localparam logic [CADR_W-1:0] CTR_BASE_DEF = 6'o30;

endpackage

// File: rtl/counter_cycle_scheduler_if.sv
// Counter request/acknowledge bundle between the counter sources, the
// scheduler and the sequence generator.
interface counter_cycle_scheduler_if #(
    parameter int NREQ = 8
);
    import agc_ctr_pkg::*;

    // Handshake: a source raises REQ_P/REQ_M (level); each rising edge registers
    // exactly one request. There is no ready: the scheduler answers with a
    // one-clock ACK (plus PINC or MINC) at T06 of the MCT it stole for that source.
    logic [NREQ-1:0]   REQ_P;
    logic [NREQ-1:0]   REQ_M;
    logic [NREQ-1:0]   GRANT;
    logic [NREQ-1:0]   ACK;
    logic [NREQ-1:0]   PENDING;
    logic              CTRCYC;
    logic              PINC;
    logic              MINC;
    logic [CADR_W-1:0] CADR;

    modport master (
        output REQ_P, REQ_M,
        input  GRANT, ACK, PENDING, CTRCYC, PINC, MINC, CADR
    );

    modport slave (
        input  REQ_P, REQ_M,
        output GRANT, ACK, PENDING, CTRCYC, PINC, MINC, CADR
    );

endinterface

// File: rtl/ctr_prio_enc.sv
// Combinational lowest-index-wins priority encoder with a valid flag.
module ctr_prio_enc #(
    parameter int N  = 8,
    parameter int IW = 3
) (
    input  logic [N-1:0]  req,
    output logic          valid,
    output logic [IW-1:0] idx
);

    // Scanning downward lets the lowest set index overwrite the others.
    always_comb begin
        valid = |req;
        idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) idx = IW'(i);
        end
    end

endmodule

// File: rtl/counter_cycle_scheduler.sv
// Steals instruction MCTs for PINC/MINC counter cycles: edge-captured requests,
// a T12 decision, a T06 commit, and a starvation guard on consecutive steals.
module counter_cycle_scheduler
    import agc_ctr_pkg::*;
#(
    parameter int                NREQ      = 8,
    parameter logic [CADR_W-1:0] CTR_BASE  = CTR_BASE_DEF,
    parameter int                MAX_STEAL = 4
) (
    input  logic                        SIM_CLK,
    input  logic                        SIM_RST,
    input  logic                        GOJAM,
    input  logic                        T12,
    input  logic                        T06,
    input  logic                        INHINC,
    counter_cycle_scheduler_if.slave    bus,
    output ctr_state_e                  dbg_state
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    ctr_state_e        state, state_nx;
    logic [STEAL_W-1:0] steal_cnt, steal_nx;
    logic [NREQ-1:0]   req_p_q, req_m_q;
    logic [NREQ-1:0]   pp, pm, pp_nx, pm_nx;
    logic [NREQ-1:0]   grant, grant_nx;
    logic [CADR_W-1:0] cadr, cadr_nx;
    logic              dir_plus, dir_nx;
    logic [NREQ-1:0]   rise_p, rise_m, cancel, eligible, ack_vec;
    logic              commit;
    logic              enc_valid;
    logic [IW-1:0]     enc_idx;

    assign rise_p   = bus.REQ_P & ~req_p_q;
    assign rise_m   = bus.REQ_M & ~req_m_q;
    // A source with both directions pending nets to zero and is never served.
    assign cancel   = pp & pm;
    assign eligible = pp ^ pm;

    ctr_prio_enc #(.N(NREQ), .IW(IW)) u_prio_enc (
        .req   (eligible),
        .valid (enc_valid),
        .idx   (enc_idx)
    );

    always_comb begin
        state_nx = state;
        steal_nx = steal_cnt;
        grant_nx = grant;
        cadr_nx  = cadr;
        dir_nx   = dir_plus;
        commit   = (state == ST_CYC) && T06 && !GOJAM;
        ack_vec  = commit ? grant : '0;
        pp_nx    = (pp & ~cancel & ~(dir_plus ? ack_vec : '0)) | rise_p;
        pm_nx    = (pm & ~cancel & ~(dir_plus ? '0 : ack_vec)) | rise_m;

        if (GOJAM) begin
            state_nx = ST_IDLE;
            steal_nx = '0;
            grant_nx = '0;
            cadr_nx  = '0;
            dir_nx   = 1'b0;
            pp_nx    = '0;
            pm_nx    = '0;
        end else if (T12) begin
            // Every T12 is a fresh decision, including a CYC whose T06 never came.
            if (enc_valid && !INHINC && (steal_cnt < STEAL_W'(MAX_STEAL))) begin
                state_nx = ST_CYC;
                grant_nx = NREQ'(1) << enc_idx;
                cadr_nx  = CTR_BASE + CADR_W'(enc_idx);
                dir_nx   = pp[enc_idx];
                steal_nx = (steal_cnt == '1) ? steal_cnt : steal_cnt + 1'b1;
            end else begin
                state_nx = ST_IDLE;
                steal_nx = '0;
                grant_nx = '0;
                cadr_nx  = '0;
                dir_nx   = 1'b0;
            end
        end else if (commit) begin
            state_nx = ST_POST;
        end
    end

    always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
        if (!SIM_RST) begin
            state     <= ST_IDLE;
            steal_cnt <= '0;
            req_p_q   <= '0;
            req_m_q   <= '0;
            pp        <= '0;
            pm        <= '0;
            grant     <= '0;
            cadr      <= '0;
            dir_plus  <= 1'b0;
        end else begin
            state     <= state_nx;
            steal_cnt <= steal_nx;
            req_p_q   <= bus.REQ_P;
            req_m_q   <= bus.REQ_M;
            pp        <= pp_nx;
            pm        <= pm_nx;
            grant     <= grant_nx;
            cadr      <= cadr_nx;
            dir_plus  <= dir_nx;
        end
    end

    assign bus.GRANT   = grant;
    assign bus.CADR    = cadr;
    assign bus.CTRCYC  = (state != ST_IDLE);
    assign bus.ACK     = ack_vec;
    assign bus.PINC    = commit && dir_plus;
    assign bus.MINC    = commit && !dir_plus;
    assign bus.PENDING = pp | pm;
    assign dbg_state   = state;

endmodule
